// File: rtl/ysyx_23060191_mc_ctrl.sv
// Multi-cycle core sequencer: owns PC and the instruction register, and handshakes fetch and LSU requests.
// Optional wait-state watchdog is enabled with `define MC_CTRL_WATCHDOG_EN.
module ysyx_23060191_mc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int              CNT_W    = 32,
  parameter int              TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  output logic [31:0]      inst,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_wr_en_rd,
  input  logic             dec_ebreak,
  input  logic [XLEN-1:0]  next_pc,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic             gpr_wr_en,
  output logic [XLEN-1:0]  pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted,
  output logic             err
);

  typedef enum logic [3:0] {
    S_RESET, S_IF_REQ, S_IF_WAIT, S_EXEC, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;
  logic             wd_fire;

  assign wait_st = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                   (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);

`ifdef MC_CTRL_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
  localparam int   WD_W  = ($clog2(TIMEOUT+1) < 8) ? 8 : $clog2(TIMEOUT+1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Fires on the cycle whose increment would reach TIMEOUT, so ERR follows exactly TIMEOUT wait cycles.
  assign wd_fire = wait_st && (wd_q == WD_W'(TIMEOUT-1));

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) wd_d = '0;
    else if (wait_st)       wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  localparam logic WD_EN = 1'b0;
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:    state_d = S_IF_REQ;
      S_IF_REQ:   if (ifu_req_ready) state_d = S_IF_WAIT;
      S_IF_WAIT:  if (ifu_rsp_valid) state_d = S_EXEC;
      S_EXEC: begin
        if (dec_ebreak)                     state_d = S_HALT;
        else if (dec_is_load||dec_is_store) state_d = S_MEM_REQ;
        else                                state_d = S_WB;
      end
      S_MEM_REQ:  if (lsu_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (lsu_rsp_valid) state_d = S_WB;
      S_WB:       state_d = S_IF_REQ;
      S_HALT:     state_d = S_HALT;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_RESET;
    endcase
    // A handshake completing on the last allowed cycle still wins over the timeout.
    if (wd_fire && (state_d == state_q)) state_d = S_ERR;
  end

  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    cnt_d  = cnt_q;
    if ((state_q == S_IF_WAIT) && ifu_rsp_valid) inst_d = ifu_rsp_inst;
    if (state_q == S_WB) begin
      pc_d  = next_pc;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      inst_q <= 32'h0000_0013;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    ifu_req_valid = (state_q == S_IF_REQ);
    ifu_req_addr  = pc_q;
    lsu_req_valid = (state_q == S_MEM_REQ);
    gpr_wr_en     = (state_q == S_WB) && dec_wr_en_rd && !dec_is_store;
    halted        = (state_q == S_HALT) || (state_q == S_ERR);
    err           = WD_EN && (state_q == S_ERR);
  end

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060191_mc_ctrl.sv
// Directed bench for the multi-cycle sequencer; a negedge monitor checks fetch addresses and retirements against queues.
module tb_ysyx_23060191_mc_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_req_addr, ifu_rsp_inst = '0, inst;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_wr_en_rd = 1'b0, dec_ebreak = 1'b0;
  logic [31:0] next_pc = '0, pc, retire_cnt;
  logic        lsu_req_valid, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        gpr_wr_en, halted, err;

  ysyx_23060191_mc_ctrl #(.XLEN(32), .RESET_PC(RPC), .CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_wr_en_rd(dec_wr_en_rd),
    .dec_ebreak(dec_ebreak), .next_pc(next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .gpr_wr_en(gpr_wr_en), .pc(pc), .retire_cnt(retire_cnt), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    int          wr;
    int          lsu;
  } ret_t;

  ret_t        rq[$];
  logic [31:0] fq[$];
  int          checks = 0, errors = 0;
  logic [31:0] exp_pc = RPC, exp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected fetch address on each accepted fetch, and the expected
  // retirement record whenever retire_cnt moves.
  int          acc_wr = 0, acc_lsu = 0;
  logic [31:0] prev_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      acc_wr = 0; acc_lsu = 0; prev_cnt = 0;
    end else begin
      if (ifu_req_valid && ifu_req_ready) begin
        if (fq.size() == 0) chk("fetch_unexpected", 1, 0);
        else chk("fetch_addr", ifu_req_addr, fq.pop_front());
      end
      acc_wr  += int'(gpr_wr_en);
      acc_lsu += int'(lsu_req_valid);
      if (retire_cnt != prev_cnt) begin
        if (rq.size() == 0) chk("retire_unexpected", 1, 0);
        else begin
          ret_t e;
          e = rq.pop_front();
          chk("ret_pc", pc, e.pc);
          chk("ret_cnt", retire_cnt, e.cnt);
          chk("ret_wr_pulses", acc_wr, e.wr);
          chk("ret_lsu_cycles", acc_lsu, e.lsu);
        end
        acc_wr = 0; acc_lsu = 0; prev_cnt = retire_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_fetch(input logic [31:0] i, input int fdly);
    int n = 0;
    while (!ifu_req_valid && n < 50) begin step(); n++; end
    chk("ifu_wait_bound", n < 50, 1);
    repeat (fdly) step();
    chk("ifu_valid_hold", ifu_req_valid, 1);
    chk("ifu_addr_hold", ifu_req_addr, exp_pc);
    ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = i; step(); ifu_rsp_valid = 1'b0;
  endtask

  task automatic run_inst(input logic [31:0] i, input logic ld, st, wr, eb,
                          input logic [31:0] npc, input int fdly, rdy_dly, rsp_dly);
    dec_is_load = ld; dec_is_store = st; dec_wr_en_rd = wr; dec_ebreak = eb; next_pc = npc;
    fq.push_back(exp_pc);
    do_fetch(i, fdly);
    chk("inst_exec", inst, i);
    step();
    if (eb) chk("halt_after_ebreak", halted, 1);
    else begin
      if (ld || st) begin
        chk("lsu_req_valid", lsu_req_valid, 1);
        repeat (rdy_dly) step();
        lsu_req_ready = 1'b1; step(); lsu_req_ready = 1'b0;
        repeat (rsp_dly) step();
        lsu_rsp_valid = 1'b1; step(); lsu_rsp_valid = 1'b0;
      end
      exp_cnt++;
      rq.push_back('{npc, exp_cnt, (wr && !st) ? 1 : 0, (ld || st) ? rdy_dly + 1 : 0});
      chk("gpr_wr_en_wb", gpr_wr_en, wr && !st);
      chk("inst_wb", inst, i);
      step();
      exp_pc = npc;
    end
  endtask

  initial begin
    int bad;
    repeat (2) step();
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'h13);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_ifu_valid", ifu_req_valid, 0);
    chk("rst_lsu_valid", lsu_req_valid, 0);
    rst = 1'b0;
    step();
    chk("c1_ifu_valid", ifu_req_valid, 1);
    chk("c1_ifu_addr", ifu_req_addr, RPC);

    run_inst(32'h0010_0093, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 0);  // addi
    run_inst(32'h0000_2103, 1, 0, 1, 0, 32'h8000_0008, 0, 3, 2);  // lw, slow LSU
    run_inst(32'h0011_2023, 0, 1, 1, 0, 32'h8000_000c, 2, 0, 0);  // sw, wr forced
    run_inst(32'h0f40_006f, 0, 0, 1, 0, 32'h8000_0100, 0, 0, 0);  // jal
    chk("pc_after_jal", pc, 32'h8000_0100);
    chk("cnt_after_4", retire_cnt, 4);

    // Load interrupted by reset while waiting for the LSU response.
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_wr_en_rd = 1'b1; dec_ebreak = 1'b0;
    fq.push_back(exp_pc);
    do_fetch(32'h0000_2183, 0);
    step();
    lsu_req_ready = 1'b1; step(); lsu_req_ready = 1'b0;
    chk("memwait_lsu_valid", lsu_req_valid, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_lsu_valid", lsu_req_valid, 0);
    chk("midrst_ifu_valid", ifu_req_valid, 0);
    chk("midrst_pc", pc, RPC);
    chk("midrst_cnt", retire_cnt, 0);
    exp_cnt = 0; exp_pc = RPC;
    step();
    rst = 1'b0; lsu_rsp_valid = 1'b1;
    repeat (2) step();
    lsu_rsp_valid = 1'b0;
    chk("stale_rsp_ifu_valid", ifu_req_valid, 1);
    chk("stale_rsp_lsu_valid", lsu_req_valid, 0);
    chk("stale_rsp_cnt", retire_cnt, 0);

    // Three ALU ops then ebreak.
    run_inst(32'h0010_0093, 0, 0, 1, 0, 32'h8000_0004, 0, 0, 0);
    run_inst(32'h0020_0113, 0, 0, 1, 0, 32'h8000_0008, 0, 0, 0);
    run_inst(32'h0030_0193, 0, 0, 1, 0, 32'h8000_000c, 0, 0, 0);
    run_inst(32'h0010_0073, 0, 0, 0, 1, 32'h8000_0010, 0, 0, 0);
    bad = 0;
    repeat (20) begin step(); if (ifu_req_valid || lsu_req_valid || gpr_wr_en) bad++; end
    chk("halt_no_requests", bad, 0);
    chk("halt_cnt", retire_cnt, 3);
    chk("halt_pc", pc, 32'h8000_000c);
    chk("halt_still", halted, 1);
    chk("halt_err", err, 0);

    // Fetch port that never accepts.
    rst = 1'b1; dec_ebreak = 1'b0; step();
    rst = 1'b0; step();
`ifdef MC_CTRL_WATCHDOG_EN
    repeat (15) step();
    chk("wd_c16_err", err, 0);
    chk("wd_c16_ifu_valid", ifu_req_valid, 1);
    step();
    chk("wd_err", err, 1);
    chk("wd_halted", halted, 1);
    chk("wd_ifu_valid", ifu_req_valid, 0);
`else
    bad = 0;
    repeat (300) begin step(); if (err || !ifu_req_valid) bad++; end
    chk("nowd_stall", bad, 0);
`endif
    chk("fq_drained", fq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
